// File: rtl/imem_dmem_arbiter.sv
// Shares one memory port between instruction fetch and data access: one outstanding transaction, D-priority with an I-starvation guard.
// Define ARB_ROUND_ROBIN_EN to replace the starvation guard with alternating grants on contention.
module imem_dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int INST_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req_valid_i,
  input  logic [ADDR_W-1:0]   i_addr_i,
  output logic                i_data_valid_o,
  output logic [INST_W-1:0]   i_data_o,
  input  logic                d_req_valid_i,
  input  logic                d_wen_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  input  logic [DATA_W/8-1:0] d_wmask_i,
  output logic                d_data_valid_o,
  output logic [DATA_W-1:0]   d_data_o,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic                mem_wen_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wmask_o,
  input  logic                mem_resp_valid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                busy_o
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  state_t            state;
  owner_t            owner;
  logic              grant_i;
  logic [INST_W-1:0] inst_sel;
`ifndef ARB_ROUND_ROBIN_EN
  logic [3:0]        starve_cnt;
`endif

  // A 64-bit beat carries two instructions; address bit 2 picks the half.
  generate
    if (DATA_W == 64) begin : g_sel64
      assign inst_sel = mem_addr_o[2] ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
    end else begin : g_sel32
      assign inst_sel = mem_rdata_i[INST_W-1:0];
    end
  endgenerate

  always_comb begin
    grant_i = 1'b0;
    if (i_req_valid_i && !d_req_valid_i)
      grant_i = 1'b1;
    else if (i_req_valid_i && d_req_valid_i)
`ifdef ARB_ROUND_ROBIN_EN
      grant_i = (owner == OWN_D);
`else
      grant_i = (starve_cnt == 4'(STARVE_MAX));
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      owner           <= OWN_I;
`ifndef ARB_ROUND_ROBIN_EN
      starve_cnt      <= '0;
`endif
      i_data_valid_o  <= 1'b0;
      i_data_o        <= '0;
      d_data_valid_o  <= 1'b0;
      d_data_o        <= '0;
      mem_req_valid_o <= 1'b0;
      mem_addr_o      <= '0;
      mem_wen_o       <= 1'b0;
      mem_wdata_o     <= '0;
      mem_wmask_o     <= '0;
      busy_o          <= 1'b0;
    end else begin
      i_data_valid_o <= 1'b0;
      d_data_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req_valid_i || d_req_valid_i) begin
            state           <= REQ;
            busy_o          <= 1'b1;
            mem_req_valid_o <= 1'b1;
            if (grant_i) begin
              owner       <= OWN_I;
              mem_addr_o  <= i_addr_i;
              mem_wen_o   <= 1'b0;
              mem_wdata_o <= '0;
              mem_wmask_o <= '1;
`ifndef ARB_ROUND_ROBIN_EN
              starve_cnt  <= '0;
`endif
            end else begin
              owner       <= OWN_D;
              mem_addr_o  <= d_addr_i;
              mem_wen_o   <= d_wen_i;
              mem_wdata_o <= d_wdata_i;
              mem_wmask_o <= d_wen_i ? d_wmask_i : '1;
`ifndef ARB_ROUND_ROBIN_EN
              if (i_req_valid_i && starve_cnt != 4'(STARVE_MAX))
                starve_cnt <= starve_cnt + 4'd1;
`endif
            end
          end
        end
        REQ: begin
          // Responses here can only be stale leftovers from an abandoned transaction.
          if (mem_req_ready_i) begin
            mem_req_valid_o <= 1'b0;
            state           <= WAIT;
          end
        end
        WAIT: begin
          if (mem_resp_valid_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            if (owner == OWN_I) begin
              i_data_valid_o <= 1'b1;
              i_data_o       <= inst_sel;
            end else begin
              d_data_valid_o <= 1'b1;
              d_data_o       <= mem_wen_o ? '0 : mem_rdata_i;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares the single backing memory port between the instruction-fetch side (PC/IF) and the data side (MEM stage).
- Accepts a level-held request from each side and grants one at a time. Default policy is D-priority with an I-starvation guard.
- Drives one outstanding transaction on the memory bus and returns a one-cycle data-valid pulse to the owner.
- `busy_o` feeds CTRL so it can stall the pipeline while a fetch or load/store is in flight.

Parameters:
- ADDR_W, 32, address width of both sides and the memory bus.
- DATA_W, 64, memory/data-side width; must be 32 or 64.
- INST_W, 32, instruction width returned to the I side.
- STARVE_MAX, 4, consecutive D grants with I pending before I is forced; range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- i_req_valid_i  in  1  fetch request; held high until i_data_valid_o.
- i_addr_i  in  ADDR_W  fetch address, INST_W/8-aligned.
- i_data_valid_o  out  1  one-cycle pulse, fetch data ready.
- i_data_o  out  INST_W  fetched instruction.
- d_req_valid_i  in  1  data request; held high until d_data_valid_o.
- d_wen_i  in  1  1 = store, 0 = load.
- d_addr_i  in  ADDR_W  data address.
- d_wdata_i  in  DATA_W  store data.
- d_wmask_i  in  DATA_W/8  byte enables for stores.
- d_data_valid_o  out  1  one-cycle pulse, load data ready or store acknowledged.
- d_data_o  out  DATA_W  load data; 0 for stores.
- mem_req_valid_o  out  1  memory request valid.
- mem_req_ready_i  in  1  memory accepts the request.
- mem_addr_o  out  ADDR_W  latched address.
- mem_wen_o  out  1  latched write enable.
- mem_wdata_o  out  DATA_W  latched store data.
- mem_wmask_o  out  DATA_W/8  latched mask; all ones for reads.
- mem_resp_valid_i  in  1  response valid; exactly one per accepted request, including writes.
- mem_rdata_i  in  DATA_W  response data.
- busy_o  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE, starve_cnt=0, owner=I.
  - All outputs 0, including the data buses.
  - Reset mid-transaction abandons it. No response pulse is produced, and a late mem_resp_valid_i arriving in IDLE or REQ is discarded.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - If any request is valid, choose owner. I wins if only I is valid, or if both are valid and starve_cnt==STARVE_MAX. Otherwise D wins.
  - Latch addr/wen/wdata/wmask from the owner. The I side latches wen=0, wdata=0, mask all ones.
  - Go to REQ. mem_req_valid_o rises the cycle after the request is first seen (1-cycle arbitration latency).
- REQ:
  - mem_req_valid_o=1 and mem_* outputs are stable.
  - On mem_req_ready_i=1, clear mem_req_valid_o next cycle and go to WAIT.
  - mem_resp_valid_i in REQ is ignored.
- WAIT:
  - On mem_resp_valid_i, register the data and pulse the owner's *_data_valid_o for exactly one cycle (1 cycle after the response), then go to IDLE.
  - A new arbitration can start in that same IDLE cycle, so back-to-back grants are 1 IDLE cycle apart.
- Instruction select:
  - DATA_W==64: i_data_o = mem_addr_o[2] ? rdata[63:32] : rdata[31:0].
  - DATA_W==32: i_data_o = rdata.
- d_data_o = rdata for loads, 0 for stores. The output not pulsing holds its previous value.
- Starvation counter:
  - On a D grant with i_req_valid_i=1, increment starve_cnt, saturating at STARVE_MAX.
  - On an I grant, clear to 0.
  - A D grant with I idle leaves it unchanged.
- Input timing: requests dropping while in IDLE before the grant are simply not granted. Requester inputs are don't-care after the latch.
- busy_o = (state != IDLE), registered with the state.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- When defined: on contention, grant the side that did not own the previous transaction (owner register, reset value I, so the first contention goes to D). starve_cnt is removed.
- When undefined: D-priority with the STARVE_MAX guard as described in Behaviour.

Test Plan:
- I-only fetch, DATA_W=64:
  - Stimulus: i_addr_i=0x8000_0004, memory ready immediately, rdata=0x11223344_AABBCCDD returned 2 cycles later.
  - Response: mem_req_valid_o at T+1; i_data_valid_o pulses once with 0x11223344; busy_o falls with the pulse.
- Store:
  - Stimulus: d_wen_i=1, d_addr_i=0x100, d_wdata_i=0xDEAD_BEEF_0000_0001, d_wmask_i=0x0F.
  - Response: mem_* carry exactly those values and mem_wen_o=1; after the response, d_data_valid_o pulses with d_data_o=0.
- Contention, STARVE_MAX=4, macro off:
  - Stimulus: I and D held high continuously.
  - Response: grant order D,D,D,D,I,D,D,D,D,I; starve_cnt is 0 after each I.
- Backpressure:
  - Stimulus: mem_req_ready_i low for 5 cycles.
  - Response: mem_addr_o/mem_req_valid_o stable all 5 cycles; a resp_valid injected in REQ is ignored (no data pulse).
- Reset mid-WAIT:
  - Stimulus: assert rst=0 for 1 cycle, then deliver the stale mem_resp_valid_i.
  - Response: all outputs 0, no data_valid pulse, state IDLE, next request served normally.
- ARB_ROUND_ROBIN_EN defined:
  - Stimulus: both sides requesting continuously.
  - Response: grants alternate D,I,D,I starting with D.
